// File: rtl/flow_pifo_dequeue_ctrl.sv
// Dequeue-side controller for the flow PIFO: tracks PIFO occupancy by snooping enqueues,
// paces dequeue strobes and buffers popped entries in a small output FIFO.
module flow_pifo_dequeue_ctrl #(
  parameter int unsigned NUM_FLOWS     = 16,
  parameter int unsigned PRIO_WIDTH    = 16,
  parameter int unsigned MAX_OCCUPANCY = 1024,
  parameter int unsigned DEQ_INTERVAL  = 1,
  parameter int unsigned OUT_DEPTH     = 2,
  localparam int unsigned FLOW_ID_WIDTH = $clog2(NUM_FLOWS),
  localparam int unsigned OCC_WIDTH     = $clog2(MAX_OCCUPANCY + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i__enable,
  input  logic                     i__pifo_enqueue,
  output logic                     o__pifo_dequeue,
  input  logic [PRIO_WIDTH-1:0]    i__pifo_dequeue_priority,
  input  logic [FLOW_ID_WIDTH-1:0] i__pifo_dequeue_flow_id,
  output logic                     o__out_valid,
  output logic [FLOW_ID_WIDTH-1:0] o__out_flow_id,
  output logic [PRIO_WIDTH-1:0]    o__out_priority,
  input  logic                     i__out_ready,
  output logic [OCC_WIDTH-1:0]     o__occupancy,
  output logic                     o__overflow_err
);

  localparam int unsigned PtrW    = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned CntW    = $clog2(OUT_DEPTH + 1);
  localparam int unsigned GapW    = (DEQ_INTERVAL > 2) ? $clog2(DEQ_INTERVAL) : 1;
  localparam int unsigned GapLoad = (DEQ_INTERVAL > 1) ? DEQ_INTERVAL - 2 : 0;

  localparam logic [0:0] StRun = 1'b0;
  localparam logic [0:0] StGap = 1'b1;

  localparam logic [OCC_WIDTH-1:0] OccMax  = OCC_WIDTH'(MAX_OCCUPANCY);
  localparam logic [CntW-1:0]      CntFull = CntW'(OUT_DEPTH);

  logic [0:0]               state_q, state_d;
  logic [GapW-1:0]          gap_q, gap_d;
  logic [OCC_WIDTH-1:0]     occ_q, occ_d;
  logic                     err_q, err_d;
  logic [PtrW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [FLOW_ID_WIDTH-1:0] flow_mem_q [OUT_DEPTH];
  logic [FLOW_ID_WIDTH-1:0] flow_mem_d [OUT_DEPTH];
  logic [PRIO_WIDTH-1:0]    prio_mem_q [OUT_DEPTH];
  logic [PRIO_WIDTH-1:0]    prio_mem_d [OUT_DEPTH];

  logic deq;
  logic pop;

  // Issue and pop decisions; strobe depends only on registered state and enable.
  always_comb begin
    deq = (state_q == StRun) && i__enable && (occ_q != '0) && (cnt_q < CntFull);
    pop = (cnt_q != '0) && i__out_ready;
  end

  // Pacing FSM: after each strobe, sit out DEQ_INTERVAL-1 cycles before issuing again.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      StRun: begin
        if (deq && (DEQ_INTERVAL > 1)) begin
          state_d = StGap;
          gap_d   = GapW'(GapLoad);
        end
      end
      StGap: begin
        if (gap_q == '0) begin
          state_d = StRun;
        end else begin
          gap_d = gap_q - GapW'(1);
        end
      end
      default: state_d = StRun;
    endcase
  end

  // Occupancy tracking with saturation and sticky overflow flag.
  always_comb begin
    occ_d = occ_q;
    err_d = err_q;
    if (i__pifo_enqueue && !deq) begin
      if (occ_q == OccMax) begin
        err_d = 1'b1;
      end else begin
        occ_d = occ_q + OCC_WIDTH'(1);
      end
    end else if (!i__pifo_enqueue && deq) begin
      occ_d = occ_q - OCC_WIDTH'(1);
    end
  end

  // Output FIFO: the strobe cycle's head fields are pushed at the tail.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    flow_mem_d = flow_mem_q;
    prio_mem_d = prio_mem_q;
    if (deq) begin
      flow_mem_d[wr_ptr_q] = i__pifo_dequeue_flow_id;
      prio_mem_d[wr_ptr_q] = i__pifo_dequeue_priority;
      wr_ptr_d             = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    cnt_d = cnt_q + CntW'(deq) - CntW'(pop);
  end

  // State registers with synchronous reset; FIFO contents are discarded on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StRun;
      gap_q    <= '0;
      occ_q    <= '0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(OUT_DEPTH); i++) begin
        flow_mem_q[i] <= '0;
        prio_mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      occ_q      <= occ_d;
      err_q      <= err_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      flow_mem_q <= flow_mem_d;
      prio_mem_q <= prio_mem_d;
    end
  end

  // Output drive.
  always_comb begin
    o__pifo_dequeue = deq;
    o__out_valid    = (cnt_q != '0);
    o__out_flow_id  = flow_mem_q[rd_ptr_q];
    o__out_priority = prio_mem_q[rd_ptr_q];
    o__occupancy    = occ_q;
    o__overflow_err = err_q;
  end

endmodule
